// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared RAM access-size encodings, LSU state enum and data helpers.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 12;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b10;
    localparam logic [1:0] MODE_BYTE = 2'b01;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} lsu_state_t;

    function automatic logic [31:0] mask_data(input logic [1:0] size, input logic [31:0] data);
        return size == MODE_BYTE ? {24'h0, data[7:0]} :
               size == MODE_HALF ? {16'h0, data[15:0]} : data;
    endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// mips_lsu_if: pipeline-side request/response bus of the load/store unit.
interface mips_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mips_load_ext.sv
// mips_load_ext: sign/zero extension of right-justified load data by access size.
module mips_load_ext
    import mips_mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ext
);
    assign ext = size == MODE_BYTE ? {{24{~is_unsigned & raw[7]}}, raw[7:0]} :
                 size == MODE_HALF ? {{16{~is_unsigned & raw[15]}}, raw[15:0]} : raw;
endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: single-outstanding load/store unit in front of a falling-edge data RAM.
// The response is registered one cycle after RESP so it leaves from clean flops.
module mips_lsu
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mips_lsu_if.slave         bus,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_wen,
    output logic [1:0]        mem_mode,
    input  logic [31:0]       mem_dout
);
    lsu_state_t  state, next_state;
    logic        accept, req_err;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] raw_q, ext;

    assign bus.req_ready = state == IDLE;
    assign accept        = bus.req_valid & bus.req_ready;
    assign req_err       = bus.req_size == 2'b11
                        || (bus.req_size == MODE_WORD && bus.req_addr[1:0] != 2'b00)
                        || (bus.req_size == MODE_HALF && bus.req_addr[0])
                        || (bus.req_addr >> ADDR_W) != 32'h0;

    always_comb begin
        next_state = state == IDLE  ? (accept ? (req_err ? RESP : ISSUE) : IDLE) :
                     state == ISSUE ? RESP : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    mips_load_ext u_ext (.raw(raw_q), .size(size_q), .is_unsigned(uns_q), .ext(ext));

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q           <= 1'b0;
            uns_q          <= 1'b0;
            err_q          <= 1'b0;
            size_q         <= MODE_WORD;
            raw_q          <= 32'h0;
            err_count      <= 8'h0;
            mem_addr       <= '0;
            mem_din        <= 32'h0;
            mem_wen        <= 1'b0;
            mem_mode       <= MODE_WORD;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q   <= bus.req_we;
                uns_q  <= bus.req_unsigned;
                err_q  <= req_err;
                size_q <= bus.req_size;
            end
            if (accept && req_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
            // Memory outputs live only for the single ISSUE cycle; address is sticky.
            if (accept && !req_err) begin
                mem_addr <= bus.req_addr[ADDR_W-1:0];
                mem_din  <= mask_data(bus.req_size, bus.req_wdata);
                mem_wen  <= bus.req_we;
                mem_mode <= bus.req_size;
            end else begin
                mem_din  <= 32'h0;
                mem_wen  <= 1'b0;
                mem_mode <= MODE_WORD;
            end
            if (state == ISSUE) raw_q <= mem_dout;
            bus.resp_valid <= state == RESP;
            bus.resp_err   <= state == RESP && err_q;
            bus.resp_rdata <= (state == RESP && !err_q && !we_q) ? ext : 32'h0;
        end
    end
endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: directed bench for mips_lsu paired with a falling-edge byte RAM model.
module tb_mips_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  err_count;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_wen;
    logic [1:0]  mem_mode;
    logic [31:0] mem_dout = 32'h0;
    logic [7:0]  ram [0:4095];
    int          wen_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;

    mips_lsu_if bus();

    mips_lsu dut (
        .clk(clk), .rst(rst), .bus(bus), .err_count(err_count),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen),
        .mem_mode(mem_mode), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Little-endian byte RAM: writes and reads both sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_wen) begin
            wen_cnt <= wen_cnt + 1;
            ram[mem_addr] <= mem_din[7:0];
            if (mem_mode != 2'b01) ram[mem_addr + 12'd1] <= mem_din[15:8];
            if (mem_mode == 2'b00) begin
                ram[mem_addr + 12'd2] <= mem_din[23:16];
                ram[mem_addr + 12'd3] <= mem_din[31:24];
            end
        end
        mem_dout <= mem_mode == 2'b01 ? {24'h0, ram[mem_addr]} :
                    mem_mode == 2'b10 ? {16'h0, ram[mem_addr + 12'd1], ram[mem_addr]} :
                    {ram[mem_addr + 12'd3], ram[mem_addr + 12'd2], ram[mem_addr + 12'd1], ram[mem_addr]};
    end

    // Presents one request from IDLE; lat counts cycles from the accept cycle to the
    // response cycle (accept cycle = 1); once = response gone and outputs zero a cycle later.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat, output logic once);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = -1; rd = 32'hx; er = 1'bx;
        for (int k = 2; k <= 8; k++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) begin
                lat = k; rd = bus.resp_rdata; er = bus.resp_err;
                break;
            end
        end
        @(posedge clk); #1;
        once = !bus.resp_valid && bus.resp_rdata == 32'h0 && !bus.resp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_hs ready=%b valid=%b exp 1/0", bus.req_ready, bus.resp_valid); end
        vectors++; if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0 || err_count !== 8'h0) begin miscompares++; $display("FAIL reset_resp rdata=%h err=%b cnt=%0d exp 0", bus.resp_rdata, bus.resp_err, err_count); end
        vectors++; if (mem_addr !== 12'h0 || mem_din !== 32'h0 || mem_wen !== 1'b0 || mem_mode !== 2'b00) begin miscompares++; $display("FAIL reset_mem addr=%h din=%h wen=%b mode=%b exp 0", mem_addr, mem_din, mem_wen, mem_mode); end
        rst = 1'b0; bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (wen_cnt !== 0 || bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_drop wen_cnt=%0d ready=%b exp 0/1", wen_cnt, bus.req_ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er, once; int lat;
        issue(1'b1, 2'b00, 1'b0, 32'h010, 32'hDEADBEEF, rd, er, lat, once);
        vectors++; if (lat !== 3 || er !== 1'b0 || rd !== 32'h0 || !once) begin miscompares++; $display("FAIL sw_resp lat=%0d err=%b rdata=%h once=%b exp 3/0/0/1", lat, er, rd, once); end
        vectors++; if ({ram[12'h013], ram[12'h012], ram[12'h011], ram[12'h010]} !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_ram got %h%h%h%h exp deadbeef", ram[12'h013], ram[12'h012], ram[12'h011], ram[12'h010]); end
        issue(1'b0, 2'b00, 1'b1, 32'h010, 32'h0, rd, er, lat, once);
        vectors++; if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF || !once) begin miscompares++; $display("FAIL lw lat=%0d err=%b rdata=%h once=%b exp 3/0/deadbeef/1", lat, er, rd, once); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er, once; int lat;
        issue(1'b1, 2'b00, 1'b0, 32'h020, 32'h11223344, rd, er, lat, once);
        issue(1'b1, 2'b01, 1'b0, 32'h021, 32'h00000080, rd, er, lat, once);
        vectors++; if (lat !== 3 || er !== 1'b0) begin miscompares++; $display("FAIL sb_resp lat=%0d err=%b exp 3/0", lat, er); end
        vectors++; if (ram[12'h020] !== 8'h44 || ram[12'h021] !== 8'h80 || ram[12'h022] !== 8'h22) begin miscompares++; $display("FAIL sb_ram got %h %h %h exp 44 80 22", ram[12'h020], ram[12'h021], ram[12'h022]); end
        issue(1'b0, 2'b01, 1'b0, 32'h021, 32'h0, rd, er, lat, once);
        vectors++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin miscompares++; $display("FAIL lb rdata=%h err=%b exp ffffff80/0", rd, er); end
        issue(1'b0, 2'b01, 1'b1, 32'h021, 32'h0, rd, er, lat, once);
        vectors++; if (rd !== 32'h00000080 || er !== 1'b0) begin miscompares++; $display("FAIL lbu rdata=%h err=%b exp 00000080/0", rd, er); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er, once; int lat;
        issue(1'b1, 2'b00, 1'b0, 32'h030, 32'hA5A5A5A5, rd, er, lat, once);
        issue(1'b1, 2'b10, 1'b0, 32'h032, 32'h12348001, rd, er, lat, once);
        vectors++; if ({ram[12'h033], ram[12'h032], ram[12'h031], ram[12'h030]} !== 32'h8001A5A5) begin miscompares++; $display("FAIL sh_ram got %h%h%h%h exp 8001a5a5", ram[12'h033], ram[12'h032], ram[12'h031], ram[12'h030]); end
        issue(1'b0, 2'b10, 1'b0, 32'h032, 32'h0, rd, er, lat, once);
        vectors++; if (rd !== 32'hFFFF8001 || lat !== 3) begin miscompares++; $display("FAIL lh rdata=%h lat=%0d exp ffff8001/3", rd, lat); end
        issue(1'b0, 2'b10, 1'b1, 32'h032, 32'h0, rd, er, lat, once);
        vectors++; if (rd !== 32'h00008001 || er !== 1'b0) begin miscompares++; $display("FAIL lhu rdata=%h err=%b exp 00008001/0", rd, er); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, once; int lat, w0;
        logic        ev_we   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  ev_size [4] = '{2'b00, 2'b10, 2'b11, 2'b00};
        logic [31:0] ev_addr [4] = '{32'h013, 32'h011, 32'h000, 32'h00001000};
        w0 = wen_cnt;
        for (int i = 0; i < 4; i++) begin
            issue(ev_we[i], ev_size[i], 1'b0, ev_addr[i], 32'hCAFEF00D, rd, er, lat, once);
            vectors++; if (lat !== 2 || er !== 1'b1 || rd !== 32'h0 || !once) begin miscompares++; $display("FAIL err_%0d lat=%0d err=%b rdata=%h once=%b exp 2/1/0/1", i, lat, er, rd, once); end
        end
        vectors++; if (wen_cnt !== w0) begin miscompares++; $display("FAIL err_wen writes=%0d exp 0", wen_cnt - w0); end
        vectors++; if (err_count !== 8'd4) begin miscompares++; $display("FAIL err_count got %0d exp 4", err_count); end
    endtask

    task automatic test_reset_issue();
        bool_seen: begin
            logic seen;
            seen = 1'b0;
            bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b00;
            bus.req_unsigned = 1'b0; bus.req_addr = 32'h010; bus.req_wdata = 32'h0;
            @(posedge clk); #1;
            bus.req_valid = 1'b0; rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            vectors++; if (bus.req_ready !== 1'b1 || mem_wen !== 1'b0 || err_count !== 8'h0) begin miscompares++; $display("FAIL rst_issue ready=%b wen=%b cnt=%0d exp 1/0/0", bus.req_ready, mem_wen, err_count); end
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                if (bus.resp_valid) seen = 1'b1;
            end
            vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_issue_resp resp_valid seen=%b exp 0", seen); end
        end
    endtask

    task automatic test_back_to_back();
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b11;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0;
        repeat (20) @(posedge clk);
        #1;
        vectors++; if (err_count !== 8'd10) begin miscompares++; $display("FAIL b2b_rate cnt=%0d exp 10", err_count); end
        repeat (580) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        vectors++; if (err_count !== 8'd255) begin miscompares++; $display("FAIL b2b_sat cnt=%0d exp 255", err_count); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (err_count !== 8'd255 || bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_hold cnt=%0d ready=%b exp 255/1", err_count, bus.req_ready); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_issue();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
